// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: datapath width, opcode encoding,
// arbiter FSM states and a behavioural reference for the ALU function.
package alu_pkg;

    localparam int N   = 8;
    localparam int SHW = $clog2(N);

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        SHL  = 3'd5,
        SHR  = 3'd6,
        SLTU = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Shift amounts use only the low SHW bits of b; SLTU yields 0 or 1.
    function automatic logic [N-1:0] alu_ref(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input alu_op_t op);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SHL:     return a << b[SHW-1:0];
            SHR:     return a >> b[SHW-1:0];
            SLTU:    return {{(N-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational N-bit ALU implementing the eight alu_pkg opcodes.
module alu
    import alu_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_t      op,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SHL:     y = a << b[SHW-1:0];
            SHR:     y = a >> b[SHW-1:0];
            SLTU:    y = {{(N-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; one operation
// in flight at a time, sequenced IDLE -> EXEC -> RESP.
module alu_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0][N-1:0]        req_a,
    input  logic [NREQ-1:0][N-1:0]        req_b,
    input  logic [NREQ-1:0][2:0]          req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [N-1:0]                  rsp_y,
    output logic                          busy
);

    localparam int IW = $clog2(NREQ);

    // Handshakes: a request transfers on req_valid[i] & req_ready[i] (ready
    // only in IDLE, one-hot on the granted index); a result transfers on
    // rsp_valid & rsp_ready, with rsp_id/rsp_y held until that cycle.

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_id;
    logic          gnt_any;
    logic          accept;

    logic [N-1:0]  lat_a, lat_b;
    alu_op_t       lat_op;
    logic [IW-1:0] lat_id;
    logic [N-1:0]  alu_y;

    // Scan from rr_ptr upward, wrapping at NREQ; first valid index wins.
    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = IW'(j);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // Gating with rst keeps req_ready low for the whole reset window.
    assign accept = (state == IDLE) && gnt_any && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            lat_a  <= '0;
            lat_b  <= '0;
            lat_op <= ADD;
            lat_id <= '0;
            rsp_y  <= '0;
            rsp_id <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_a  <= req_a[gnt_id];
                lat_b  <= req_b[gnt_id];
                lat_op <= alu_op_t'(req_op[gnt_id]);
                lat_id <= gnt_id;
                rr_ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                rsp_y  <= alu_y;
                rsp_id <= lat_id;
            end
        end
    end

    alu u_alu (
        .a  (lat_a),
        .b  (lat_b),
        .op (lat_op),
        .y  (alu_y)
    );

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: opcode vector table, contention, backpressure,
// wrap-around and reset-during-operation sequences with a result scoreboard.
module tb_alu_arb;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);
    localparam int EW   = IW + N;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][N-1:0] req_a;
    logic [NREQ-1:0][N-1:0] req_b;
    logic [NREQ-1:0][2:0]   req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [N-1:0]           rsp_y;
    logic                   busy;

    alu_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_pulses    = 0;
    int grant_cyc       = -1;
    int first_valid_cyc = -1;
    logic prev_valid    = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    logic [EW-1:0] exp_e;

    typedef struct {
        int           idx;
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] y;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int id, input int y);
        return {IW'(id), N'(y)};
    endfunction

    task automatic check_log(input string name, input int want[$]);
        check({name, "_len"}, grant_log.size(), want.size());
        for (int i = 0; i < want.size() && i < grant_log.size(); i++)
            check(name, grant_log[i], want[i]);
    endtask

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (|req_ready) begin
                ready_pulses++;
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                check("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
                check("ready_only_idle", 32'(busy), 0);
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) begin
                        grant_log.push_back(i);
                        grant_cyc = cyc;
                    end
            end
            if (rsp_valid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(exp_e[EW-1:N]));
                    check("rsp_y", 32'(rsp_y), 32'(exp_e[N-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] op);
        @(posedge clk); #1;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_op[idx]    = op;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[idx]) break;
        end
        check("grant_wait", 32'(req_ready[idx]), 1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        exp_q.delete();
        ready_pulses    = 0;
        grant_cyc       = -1;
        first_valid_cyc = -1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int want[$];
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        vecs[0]  = '{0, ADD,  73,  42, 115};
        vecs[1]  = '{1, SUB,  73,  42,  31};
        vecs[2]  = '{2, AND,  73,  42,   8};
        vecs[3]  = '{3, OR,   73,  42, 107};
        vecs[4]  = '{0, XOR,  73,  42,  99};
        vecs[5]  = '{1, SHL,  73,  42,  36};
        vecs[6]  = '{2, SHR,  73,  42,  18};
        vecs[7]  = '{3, SLTU, 73,  42,   0};
        vecs[8]  = '{0, SUB,   0,   1, 255};
        vecs[9]  = '{1, ADD, 200, 100,  44};
        vecs[10] = '{2, SLTU,  3,   9,   1};
        vecs[11] = '{3, SHR, 255,   7,   1};

        // Reset values, with every requester asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_y", 32'(rsp_y), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        do_reset();

        // Single request on index 2.
        exp_q.push_back(mk(2, 115));
        issue(2, 73, 42, ADD);
        wait_drain();
        @(negedge clk);
        check("single_busy_drop", 32'(busy), 0);
        check("single_pulses", ready_pulses, 1);
        check("single_latency", first_valid_cyc - grant_cyc, 2);
        want = '{2};
        check_log("single_grant", want);

        // Contention: all four valid, two rounds each.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) exp_q.push_back(mk(i, 9 * i));
        for (int i = 0; i < NREQ; i++) begin
            automatic int ii = i;
            fork
                begin
                    issue(ii, N'(10 * ii), N'(ii), SUB);
                    issue(ii, N'(10 * ii), N'(ii), SUB);
                end
            join_none
        end
        wait fork;
        wait_drain();
        want = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr_order", want);

        // Backpressure: result held for 5 cycles while another request waits.
        do_reset();
        rsp_ready = 1'b0;
        exp_q.push_back(mk(1, 145));
        issue(1, 200, 55, SUB);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("bp_valid", 32'(rsp_valid), 1);
        exp_q.push_back(mk(0, 11));
        fork
            issue(0, 5, 6, ADD);
        join_none
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_y", 32'(rsp_y), 145);
            check("bp_hold_id", 32'(rsp_id), 1);
            check("bp_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait fork;
        wait_drain();
        want = '{1, 0};
        check_log("bp_grants", want);

        // Wrap-around: after index 3, index 0 has priority over 3.
        do_reset();
        exp_q.push_back(mk(3, 7));
        issue(3, 3, 4, ADD);
        wait_drain();
        exp_q.push_back(mk(0, 2));
        exp_q.push_back(mk(3, 9));
        fork
            issue(0, 1, 1, ADD);
            issue(3, 4, 5, ADD);
        join
        wait_drain();
        want = '{3, 0, 3};
        check_log("wrap_grants", want);

        // Reset while the operation is in EXEC.
        do_reset();
        @(posedge clk); #1;
        req_a[2] = 73; req_b[2] = 42; req_op[2] = ADD; req_valid[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[2]) break;
        end
        check("midop_grant", 32'(req_ready[2]), 1);
        @(posedge clk); #1;
        req_valid = 4'b1010;
        check("midop_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midop_busy_rst", 32'(busy), 0);
        check("midop_valid_rst", 32'(rsp_valid), 0);
        check("midop_y_rst", 32'(rsp_y), 0);
        check("midop_id_rst", 32'(rsp_id), 0);
        check("midop_ready_rst", 32'(req_ready), 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midop_no_rsp", 32'(rsp_valid), 0);
        end
        grant_log.delete();
        exp_q.push_back(mk(1, 10));
        exp_q.push_back(mk(3, 3));
        fork
            issue(3, 1, 2, ADD);
            issue(1, 5, 5, ADD);
        join
        wait_drain();
        want = '{1, 3};
        check_log("midop_grants", want);

        // Opcode vectors.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(mk(vecs[i].idx, int'(vecs[i].y)));
            issue(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op);
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter NREQ, default 4, SHALL be the number of requesters sharing the ALU (2..8).
REQ-003 Parameter N SHALL come from alu_pkg and set the operand and result width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept strobe.
REQ-008 req_a, req_b  input  NREQ x N  per-requester operands.
REQ-009 req_op  input  NREQ x 3  per-requester opcode in alu_pkg encoding.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester owning rsp_y.
REQ-013 rsp_y  output  N  ALU result.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP, with transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, and RESP->IDLE on rsp_ready.
REQ-016 In IDLE, the block SHALL assert combinationally exactly one req_ready bit, for the granted index, and only when at least one req_valid is high; all req_ready bits SHALL be 0 in EXEC and RESP.
REQ-017 Grant SHALL be round-robin: the search starts at rr_ptr and wraps modulo NREQ, and the first index with req_valid high wins.
REQ-018 On accept (req_valid & req_ready), the block SHALL latch A, B, op and id, set rr_ptr to (id+1) mod NREQ (NREQ-1 wraps to 0), and enter EXEC.
REQ-019 In EXEC, the ALU SHALL be driven only from the latched registers, and rsp_y and rsp_id SHALL be registered at the end of the cycle.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_y and rsp_id SHALL be held stable until the cycle in which rsp_ready is 1.
REQ-021 Latency SHALL be as follows: with accept at clock edge t, rsp_valid is high from edge t+2; the minimum issue interval is 3 cycles.
REQ-022 rsp_ready asserted while rsp_valid is 0 SHALL have no effect.
REQ-023 A requester not yet granted MAY drop req_valid without side effect; req_valid SHALL NOT depend on req_ready.
REQ-024 Requests arriving in EXEC or RESP SHALL wait, unaccepted, until the next IDLE cycle.
REQ-025 When all NREQ requesters are continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0.

Reset
REQ-026 Reset SHALL force state IDLE, rr_ptr 0, rsp_valid 0, rsp_y 0, rsp_id 0, req_ready 0 and busy 0.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no rsp_valid pulse SHALL follow the release.
REQ-028 On the first IDLE cycle after reset, index 0 SHALL have top priority.

Structure
REQ-029 alu_pkg SHALL hold N, the opcode encoding/typedef and the arb_state_t enum {IDLE, EXEC, RESP}.
REQ-030 The block SHALL instantiate exactly one existing alu module as its sole sub-module; round-robin logic stays inline.
REQ-031 alu_pkg SHALL define ADD = 3'd0 and SUB = 3'd1 for use in the verification values below.

Verification
REQ-032 Single request: after reset, req 2 sends A=73, B=42, op=ADD with rsp_ready=1 -> req_ready[2] pulses once, rsp_valid goes high 2 edges later with rsp_y=115 and rsp_id=2, then busy drops.
REQ-033 Contention: reqs 0..3 are all valid with op=SUB and A=10*i, B=i, held until accepted -> rsp_id sequence is 0,1,2,3 and rsp_y is 0,9,18,27.
REQ-034 Backpressure: rsp_ready is held at 0 for 5 cycles in RESP -> rsp_valid, rsp_y and rsp_id stay stable, no req_ready pulses, and one result is delivered after rsp_ready rises.
REQ-035 Wrap-around: a sole request on index 3 is followed by simultaneous requests on 0 and 3 -> index 0 is granted next.
REQ-036 Reset mid-op: rst is asserted in EXEC -> outputs go to reset values immediately, no rsp_valid appears afterwards, and the next grant goes to the lowest valid index.
REQ-037 All 8 opcodes with A=73, B=42 -> each rsp_y matches the alu_pkg reference model.
